fwd_hazard_unit: RTL and testbench

- Parametrised forwarding and hazard unit for the pipelined MIPS core. Replaces the fixed two-source MEM/WB forwarding selector.
- Uses per-operand use flags from the decoder instead of one-hot instruction vectors.
- Accepts NSRC forwarding sources with nearest-stage priority.
- Adds a sequential load-use stall FSM with configurable bubble count, branch-flush abort and a saturating stall performance counter.

---
 rtl/fwd_hazard_unit.sv | 140 ++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the pipelined MIPS core.
// Selects the nearest matching forwarding source per operand and stalls the
// front end for LOAD_LAT cycles when an ID operand depends on an EX-stage load.
module fwd_hazard_unit #(
    parameter int unsigned NSRC     = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned SYS_REG  = 2,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned SELW     = $clog2(NSRC + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_rs_use,
    input  logic              id_rt_use,
    input  logic              id_sys,
    input  logic [4:0]        ex_rd,
    input  logic              ex_we,
    input  logic              ex_is_load,
    input  logic [5*NSRC-1:0] src_rd,
    input  logic [NSRC-1:0]   src_we,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [SELW-1:0]   rs_sel,
    output logic [SELW-1:0]   rt_sel,
    output logic              stall,
    output logic              bubble,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned REM_W = $clog2(LOAD_LAT) + 1;

    typedef enum logic [0:0] {
        StIdle,
        StHold
    } state_e;

    state_e             state_q, state_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         rs_eff;
    logic               rs_used;
    logic               rt_used;
    logic               haz;
    logic               stall_raw;

    assign rs_eff  = id_sys ? 5'(SYS_REG) : id_rs;
    assign rs_used = id_rs_use | id_sys;
    assign rt_used = id_rt_use;

    // Forwarding select: scan furthest to nearest so the lowest index wins.
    always_comb begin
        rs_sel = '0;
        rt_sel = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (src_we[k] && (src_rd[5*k +: 5] != 5'd0)) begin
                if (rs_used && (src_rd[5*k +: 5] == rs_eff)) begin
                    rs_sel = SELW'(k + 1);
                end
                if (rt_used && (src_rd[5*k +: 5] == id_rt)) begin
                    rt_sel = SELW'(k + 1);
                end
            end
        end
    end

    // Load-use hazard against the instruction currently in EX.
    always_comb begin
        haz = ex_is_load && ex_we && (ex_rd != 5'd0) &&
              ((rs_used && (ex_rd == rs_eff)) || (rt_used && (ex_rd == id_rt)));
    end

    // Stall FSM next state; flush aborts any stall run from either state.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        stall_raw = 1'b0;
        if (flush) begin
            state_d = StIdle;
            rem_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (haz) begin
                        stall_raw = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = StHold;
                            rem_d   = REM_W'(LOAD_LAT - 1);
                        end
                    end
                end
                StHold: begin
                    // New hazards are ignored until the current run completes.
                    stall_raw = 1'b1;
                    rem_d     = rem_q - 1'b1;
                    if (rem_q == REM_W'(1)) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                    rem_d   = '0;
                end
            endcase
        end
    end

    // Outputs are masked by reset so a stall in progress drops immediately.
    always_comb begin
        stall  = stall_raw & rst_n;
        bubble = stall_raw & rst_n;
    end

    // Saturating stall counter; clear takes priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign stall_cnt = cnt_q;

    // State, remaining-bubble and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a forwarding vector table plus hand-written
// stall sequences on a LOAD_LAT=1 instance and a LOAD_LAT=3, CNT_W=4 instance.
module tb_fwd_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs, id_rt;
    logic       id_rs_use, id_rt_use, id_sys;
    logic [4:0] ex_rd;
    logic       ex_we, ex_is_load;
    logic [9:0] src_rd;
    logic [1:0] src_we;
    logic       flush, cnt_clr;

    logic [1:0]  rs_sel1, rt_sel1, rs_sel3, rt_sel3;
    logic        stall1, bubble1, stall3, bubble3;
    logic [15:0] cnt1;
    logic [3:0]  cnt3;

    int n_chk;
    int n_fail;

    fwd_hazard_unit #(.NSRC(2), .LOAD_LAT(1), .SYS_REG(2), .CNT_W(16)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_use(id_rs_use), .id_rt_use(id_rt_use), .id_sys(id_sys),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load),
        .src_rd(src_rd), .src_we(src_we), .flush(flush), .cnt_clr(cnt_clr),
        .rs_sel(rs_sel1), .rt_sel(rt_sel1), .stall(stall1), .bubble(bubble1),
        .stall_cnt(cnt1)
    );

    fwd_hazard_unit #(.NSRC(2), .LOAD_LAT(3), .SYS_REG(2), .CNT_W(4)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_use(id_rs_use), .id_rt_use(id_rt_use), .id_sys(id_sys),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load),
        .src_rd(src_rd), .src_we(src_we), .flush(flush), .cnt_clr(cnt_clr),
        .rs_sel(rs_sel3), .rt_sel(rt_sel3), .stall(stall3), .bubble(bubble3),
        .stall_cnt(cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rs_use;
        logic       rt_use;
        logic       sys;
        logic [4:0] s1_rd;
        logic [4:0] s0_rd;
        logic [1:0] we;
        logic [1:0] exp_rs;
        logic [1:0] exp_rt;
    } fwd_vec_t;

    fwd_vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load in EX writing r8 while ID reads r8 as rt.
    task automatic set_haz(input logic on);
        ex_is_load = on;
        ex_we      = on;
        ex_rd      = 5'd8;
        id_rt      = 5'd8;
        id_rt_use  = on;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; id_rs_use = 0; id_rt_use = 0; id_sys = 0;
        ex_rd = '0; ex_we = 0; ex_is_load = 0;
        src_rd = '0; src_we = '0; flush = 0; cnt_clr = 0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        //            rs     rt     rsu rtu sys s1rd   s0rd   we     ers ert
        vecs[0] = '{5'd5, 5'd0, 1, 0, 0, 5'd5, 5'd5, 2'b11, 2'd1, 2'd0};
        vecs[1] = '{5'd5, 5'd0, 1, 0, 0, 5'd5, 5'd5, 2'b10, 2'd2, 2'd0};
        vecs[2] = '{5'd0, 5'd0, 1, 1, 0, 5'd0, 5'd0, 2'b11, 2'd0, 2'd0};
        vecs[3] = '{5'd9, 5'd0, 0, 0, 1, 5'd2, 5'd9, 2'b11, 2'd2, 2'd0};
        vecs[4] = '{5'd9, 5'd0, 0, 0, 1, 5'd2, 5'd9, 2'b01, 2'd0, 2'd0};
        vecs[5] = '{5'd3, 5'd7, 0, 1, 0, 5'd7, 5'd3, 2'b11, 2'd0, 2'd2};
        vecs[6] = '{5'd3, 5'd7, 1, 0, 0, 5'd7, 5'd3, 2'b11, 2'd1, 2'd0};
        vecs[7] = '{5'd4, 5'd4, 1, 1, 0, 5'd4, 5'd4, 2'b10, 2'd2, 2'd2};

        clear_inputs();
        rst_n = 0;
        set_haz(1);
        settle();
        chk("reset_stall_masked", stall1, 0);
        chk("reset_bubble_masked", bubble3, 0);
        chk("reset_cnt1", cnt1, 0);
        chk("reset_cnt3", cnt3, 0);
        tick();
        set_haz(0);
        rst_n = 1;
        tick();

        // Forwarding table.
        for (int i = 0; i < 8; i++) begin
            id_rs     = vecs[i].rs;
            id_rt     = vecs[i].rt;
            id_rs_use = vecs[i].rs_use;
            id_rt_use = vecs[i].rt_use;
            id_sys    = vecs[i].sys;
            src_rd    = {vecs[i].s1_rd, vecs[i].s0_rd};
            src_we    = vecs[i].we;
            settle();
            chk($sformatf("fwd%0d_rs_sel", i), rs_sel1, vecs[i].exp_rs);
            chk($sformatf("fwd%0d_rt_sel", i), rt_sel1, vecs[i].exp_rt);
            chk($sformatf("fwd%0d_rs_sel_l3", i), rs_sel3, vecs[i].exp_rs);
            chk($sformatf("fwd%0d_no_stall", i), stall1, 0);
        end
        clear_inputs();
        tick();

        // Single load-use hazard: 1 stall on lat1, 3 consecutive on lat3.
        set_haz(1);
        settle();
        chk("haz_c1_stall1", stall1, 1);
        chk("haz_c1_bubble1", bubble1, 1);
        chk("haz_c1_stall3", stall3, 1);
        tick();
        set_haz(0);
        settle();
        chk("haz_c2_stall1", stall1, 0);
        chk("haz_c2_cnt1", cnt1, 1);
        chk("haz_c2_stall3", stall3, 1);
        chk("haz_c2_bubble3", bubble3, 1);
        tick();
        chk("haz_c3_stall3", stall3, 1);
        tick();
        chk("haz_c4_stall3", stall3, 0);
        chk("haz_c4_cnt3", cnt3, 3);
        chk("haz_c4_cnt1", cnt1, 1);
        tick();

        // Load-like cases that must not stall.
        set_haz(1);
        id_rt_use = 0;
        settle();
        chk("no_use_stall1", stall1, 0);
        chk("no_use_stall3", stall3, 0);
        id_rt_use = 1;
        ex_rd = 5'd0;
        id_rt = 5'd0;
        settle();
        chk("r0_load_stall1", stall1, 0);
        set_haz(0);

        // Syscall hazard on implicit $v0.
        ex_is_load = 1; ex_we = 1; ex_rd = 5'd2; id_sys = 1; id_rs = 5'd9;
        settle();
        chk("sys_haz_stall1", stall1, 1);
        flush = 1;
        settle();
        chk("flush_over_haz_stall1", stall1, 0);
        chk("flush_over_haz_stall3", stall3, 0);
        clear_inputs();

        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        settle();
        chk("clr_cnt1", cnt1, 0);
        chk("clr_cnt3", cnt3, 0);

        // Flush in the second cycle of a lat3 stall run.
        set_haz(1);
        settle();
        chk("fl_c1_stall3", stall3, 1);
        tick();
        set_haz(0);
        flush = 1;
        settle();
        chk("fl_c2_stall3", stall3, 0);
        chk("fl_c2_bubble3", bubble3, 0);
        tick();
        flush = 0;
        settle();
        chk("fl_c3_stall3", stall3, 0);
        chk("fl_c3_cnt3", cnt3, 1);
        chk("fl_c3_cnt1", cnt1, 1);
        tick();

        // Continuous hazard for 20 cycles: lat3 counter saturates at 15.
        set_haz(1);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall1", stall1, 1);
        chk("sat_cnt3", cnt3, 15);
        chk("sat_cnt1", cnt1, 21);
        set_haz(0);
        flush   = 1;
        cnt_clr = 1;
        tick();
        flush   = 0;
        cnt_clr = 0;
        settle();
        chk("sat_clr_cnt3", cnt3, 0);
        chk("sat_clr_cnt1", cnt1, 0);
        chk("sat_clr_stall3", stall3, 0);

        // Reset asserted mid-HOLD.
        set_haz(1);
        settle();
        tick();
        set_haz(0);
        settle();
        chk("rst_hold_stall3_pre", stall3, 1);
        chk("rst_hold_cnt3_pre", cnt3, 1);
        rst_n = 0;
        id_rs = 5'd5; id_rs_use = 1; src_rd = {5'd0, 5'd5}; src_we = 2'b01;
        settle();
        chk("rst_hold_stall3", stall3, 0);
        chk("rst_hold_bubble3", bubble3, 0);
        chk("rst_hold_cnt3", cnt3, 0);
        chk("rst_fwd_comb", rs_sel3, 1);
        tick();
        clear_inputs();
        rst_n = 1;
        settle();
        tick();
        chk("post_rst_stall3", stall3, 0);
        chk("post_rst_cnt3", cnt3, 0);
        chk("post_rst_cnt1", cnt1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
